// File: rtl/dram_byte_reader_pkg.sv
// ----------------------------------------------------------------------------
// dla_dram_pkg : shared types and helpers for the DRAM byte reader
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package dla_dram_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } rd_state_e;

  function automatic int bytes_per(input int width);
    return width / 8;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dram_byte_reader_if.sv
// ----------------------------------------------------------------------------
// dram_byte_reader_if : command, DRAM read port and packed output stream
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface dram_byte_reader_if #(
  parameter int BYTE_ADDR_WIDTH = 13,
  parameter int LEN_WIDTH       = 16,
  parameter int OUT_WIDTH       = 32
);

  logic                       cmd_valid;
  logic                       cmd_ready;
  logic [BYTE_ADDR_WIDTH-1:0] cmd_addr;
  logic [LEN_WIDTH-1:0]       cmd_len;

  logic                       dram_en;
  logic [BYTE_ADDR_WIDTH-1:0] dram_rdaddr;
  logic [7:0]                 dram_rddata;

  logic                       out_valid;
  logic                       out_ready;
  logic [OUT_WIDTH-1:0]       out_data;
  logic                       out_last;

  modport master (
    input  cmd_valid, cmd_addr, cmd_len, dram_rddata, out_ready,
    output cmd_ready, dram_en, dram_rdaddr, out_valid, out_data, out_last
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_len, dram_rddata, out_ready,
    input  cmd_ready, dram_en, dram_rdaddr, out_valid, out_data, out_last
  );

endinterface

`default_nettype wire

// File: rtl/dram_byte_reader_packer.sv
// ----------------------------------------------------------------------------
// dram_byte_packer : little-endian byte packing into a valid/ready output word
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module dram_byte_packer
  import dla_dram_pkg::*;
#(
  parameter  int OUT_WIDTH   = 32,
  localparam int BytesPerOut = bytes_per(OUT_WIDTH),
  localparam int CntWidth    = $clog2(BytesPerOut) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sync_rst,
  input  logic                 cap_en,
  input  logic                 cap_last,
  input  logic [7:0]           cap_byte,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_last,
  output logic [CntWidth-1:0]  pack_cnt,
  output logic                 final_acc
);

  logic [OUT_WIDTH-1:0] pack_q, pack_d, out_data_q, out_data_d, merged;
  logic [CntWidth-1:0]  pack_cnt_q, pack_cnt_d;
  logic                 out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic                 pend_q, pend_d, pend_last_q, pend_last_d;
  logic                 accept, out_free, complete;

  always_comb begin
    accept      = out_valid_q & out_ready;
    out_free    = ~out_valid_q | accept;
    merged      = pack_q | (OUT_WIDTH'(cap_byte) << {pack_cnt_q, 3'b000});
    complete    = (pack_cnt_q + CntWidth'(1) == CntWidth'(BytesPerOut)) | cap_last;
    pack_d      = pack_q;
    pack_cnt_d  = pack_cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q & ~accept;
    out_last_d  = out_last_q;
    pend_d      = pend_q;
    pend_last_d = pend_last_q;

    // A final partial word that met a stalled output waits here, fully merged.
    if (pend_q && out_free) begin
      out_data_d  = pack_q;
      out_valid_d = 1'b1;
      out_last_d  = pend_last_q;
      pack_d      = '0;
      pack_cnt_d  = '0;
      pend_d      = 1'b0;
    end

    if (cap_en) begin
      if (complete && out_free && !pend_q) begin
        out_data_d  = merged;
        out_valid_d = 1'b1;
        out_last_d  = cap_last;
        pack_d      = '0;
        pack_cnt_d  = '0;
      end else begin
        pack_d      = merged;
        pack_cnt_d  = pack_cnt_q + CntWidth'(1);
        if (complete) begin
          pend_d      = 1'b1;
          pend_last_d = cap_last;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pack_q      <= '0;
      pack_cnt_q  <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      pend_q      <= 1'b0;
      pend_last_q <= 1'b0;
    end else if (sync_rst) begin
      pack_q      <= '0;
      pack_cnt_q  <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      pend_q      <= 1'b0;
      pend_last_q <= 1'b0;
    end else begin
      pack_q      <= pack_d;
      pack_cnt_q  <= pack_cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      pend_q      <= pend_d;
      pend_last_q <= pend_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign pack_cnt  = pack_cnt_q;
  assign final_acc = accept & out_last_q;

endmodule

`default_nettype wire

// File: rtl/dram_byte_reader.sv
// ----------------------------------------------------------------------------
// dram_byte_reader : byte-serial DRAM read DMA feeding a packed word stream
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module dram_byte_reader
  import dla_dram_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 10,
  parameter int OUT_WIDTH  = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                CLK,
  input  logic                ASYNC_RST,
  input  logic                SYNC_RST,
  dram_byte_reader_if.master  bus,
  output logic                busy,
  output logic                done
);

  localparam int AddrWidth   = ADDR_WIDTH + $clog2(DATA_WIDTH / 8);
  localparam int BytesPerOut = bytes_per(OUT_WIDTH);
  localparam int CntWidth    = $clog2(BytesPerOut) + 1;

  rd_state_e              state_q, state_d;
  logic [AddrWidth-1:0]   cur_addr_q, cur_addr_d;
  logic [LEN_WIDTH-1:0]   remaining_q, remaining_d;
  logic                   in_flight_q, in_flight_d, in_last_q, in_last_d;
  logic                   cmd_ready, dram_en, issue_ok;
  logic                   out_valid, final_acc;
  logic [CntWidth-1:0]    pack_cnt;
  logic [CntWidth+1:0]    fill_sum;

  dram_byte_packer #(.OUT_WIDTH(OUT_WIDTH)) u_packer (
    .clk       (CLK),
    .rst_n     (ASYNC_RST),
    .sync_rst  (SYNC_RST),
    .cap_en    (in_flight_q),
    .cap_last  (in_last_q),
    .cap_byte  (bus.dram_rddata),
    .out_ready (bus.out_ready),
    .out_valid (out_valid),
    .out_data  (bus.out_data),
    .out_last  (bus.out_last),
    .pack_cnt  (pack_cnt),
    .final_acc (final_acc)
  );

  // Only issue when the byte it produces is guaranteed a place to land.
  assign fill_sum = (CntWidth+2)'(pack_cnt) + (CntWidth+2)'(in_flight_q) + (CntWidth+2)'(1);
  assign issue_ok = (fill_sum < (CntWidth+2)'(BytesPerOut)) || !out_valid || bus.out_ready;

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    in_flight_d = 1'b0;
    in_last_d   = 1'b0;
    cmd_ready   = 1'b0;
    dram_en     = 1'b0;
    done        = 1'b0;
    busy        = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          cur_addr_d  = bus.cmd_addr;
          remaining_d = bus.cmd_len;
          state_d     = (bus.cmd_len == '0) ? DONE : READ;
        end
      end
      READ: begin
        if (remaining_q != '0 && issue_ok) begin
          dram_en     = 1'b1;
          cur_addr_d  = cur_addr_q + AddrWidth'(1);
          remaining_d = remaining_q - LEN_WIDTH'(1);
          in_flight_d = 1'b1;
          in_last_d   = (remaining_q == LEN_WIDTH'(1));
          if (remaining_q == LEN_WIDTH'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (final_acc) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge ASYNC_RST) begin
    if (!ASYNC_RST) begin
      state_q     <= IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      in_flight_q <= 1'b0;
      in_last_q   <= 1'b0;
    end else if (SYNC_RST) begin
      state_q     <= IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      in_flight_q <= 1'b0;
      in_last_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      in_flight_q <= in_flight_d;
      in_last_q   <= in_last_d;
    end
  end

  assign bus.cmd_ready   = cmd_ready;
  assign bus.dram_en     = dram_en;
  assign bus.dram_rdaddr = dram_en ? cur_addr_q : '0;
  assign bus.out_valid   = out_valid;

endmodule

`default_nettype wire
